multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control FSM for the multicycle MIPS-subset CPU. Sequences the shared datapath (PC, instruction register, register file, single ALU, unified memory) through fetch, decode, execute, memory and write-back steps. It drives every write enable and mux select, including the instruction register's `ir_we`, and decodes the opcode and funct fields latched by that register. It also keeps a retired-instruction counter for debug.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  6  IR bits [31:26]
- funct  in  6  IR bits [5:0]
- zero  in  1  ALU zero flag (combinational, current cycle)
- pc_we  out  1  PC write enable
- ir_we  out  1  instruction register write enable
- mem_we  out  1  memory write enable
- reg_we  out  1  register file write enable
- mem_addr_sel  out  1  0=PC, 1=ALUOut register
- reg_dst_sel  out  2  0=Rt, 1=Rd, 2=R31
- reg_wd_sel  out  2  0=ALUOut, 1=memory data register, 2=PC
- alu_a_sel  out  1  0=PC, 1=A register
- alu_b_sel  out  2  0=B register, 1=const 4, 2=sign-ext imm16, 3=sign-ext imm16<<2
- alu_op  out  2  0=ADD, 1=SUB, 2=XOR, 3=SLT
- pc_src_sel  out  2  0=ALU result, 1={PC[31:28],instr[25:0],2'b00}, 2=A register, 3=ALUOut register
- retired  out  CNT_W  instructions fetched since reset
- illegal  out  1  illegal-opcode halt flag (0 without macro)

## Operation
- Opcodes: LW 0x23, SW 0x2B, J 0x02, JAL 0x03, BNE 0x05, ADDI 0x08, XORI 0x0E, R-type 0x00 with funct ADD 0x20, SUB 0x22, SLT 0x2A, JR 0x08.
- Outputs are a Moore decode of the state register. The one exception: in BRANCH, pc_we = !zero.
- Unlisted outputs are 0 in each state. XORI uses alu_b_sel=2; the datapath zero-extends for XOR.
- FETCH: mem_addr_sel=0, ir_we=1, alu_a_sel=0, alu_b_sel=1, alu_op=ADD, pc_src_sel=0, pc_we=1 -> DECODE.
- DECODE: alu_a_sel=0, alu_b_sel=3, ADD (branch target into ALUOut). Next state by opcode:
  - LW/SW -> MEM_ADDR
  - R-type ADD/SUB/SLT -> EX_R
  - funct JR -> JR
  - ADDI/XORI -> EX_I
  - BNE -> BRANCH
  - J -> JUMP
  - JAL -> JAL
  - anything else -> see Configuration.
- MEM_ADDR: alu_a_sel=1, alu_b_sel=2, ADD. LW -> MEM_RD; SW -> MEM_WR.
- MEM_RD: mem_addr_sel=1 -> MEM_WB.
- MEM_WB: reg_we=1, reg_dst_sel=0, reg_wd_sel=1 -> FETCH.
- MEM_WR: mem_addr_sel=1, mem_we=1 -> FETCH.
- EX_R: alu_a_sel=1, alu_b_sel=0, alu_op from funct -> WB_R.
- WB_R: reg_we=1, reg_dst_sel=1, reg_wd_sel=0 -> FETCH.
- EX_I: alu_a_sel=1, alu_b_sel=2, ADD (ADDI) or XOR (XORI) -> WB_I.
- WB_I: reg_we=1, reg_dst_sel=0, reg_wd_sel=0 -> FETCH.
- BRANCH: alu_a_sel=1, alu_b_sel=0, SUB, pc_src_sel=3, pc_we=!zero -> FETCH.
- JUMP: pc_src_sel=1, pc_we=1 -> FETCH.
- JR: pc_src_sel=2, pc_we=1 -> FETCH.
- JAL: reg_we=1, reg_dst_sel=2, reg_wd_sel=2 (PC already +4), pc_src_sel=1, pc_we=1 -> FETCH.
- retired increments by 1 on each cycle with ir_we=1 and wraps from 2^CNT_W-1 to 0.

## Timing
- Reset (sampled at posedge): state <= FETCH, retired <= 0, illegal <= 0.
- While reset is high, all four write enables are forced 0 combinationally. The first fetch is the cycle after reset deasserts.
- Reset asserted mid-instruction abandons it; no partial write occurs after the reset edge.
- Cycles per instruction, FETCH through last state inclusive:
  - LW 5
  - SW, R-type, ADDI, XORI 4
  - BNE, J, JR, JAL 3
- opcode/funct are valid from DECODE onward, since the IR captured them at the end of FETCH. They are ignored in FETCH.
- Exactly one ir_we pulse per instruction.

## Configuration
- MC_CTRL_ILLEGAL_TRAP_EN defined:
  - An unknown opcode or funct in DECODE goes to HALT.
  - HALT holds all enables 0 and sets illegal=1.
  - Only reset exits HALT.
- MC_CTRL_ILLEGAL_TRAP_EN undefined:
  - An unknown encoding goes from DECODE to FETCH (2-cycle NOP).
  - illegal is tied 0 and HALT is not built.

## Structure
- Shared package `mc_pkg`: opcode/funct constants, alu_op encodings, mux-select encodings, and the state enum.
- One natural sub-module, `mc_decode`: combinational map from {opcode, funct} to an instruction class (MEM_LD, MEM_ST, RTYPE, JR, ITYPE, BNE, J, JAL, ILLEGAL). It also produces the R-type alu_op.
- The FSM and counter stay in `multicycle_control`.

## Test plan
- Reset held 3 cycles then released -> all enables 0 during reset; ir_we=1, pc_we=1 on the first post-reset cycle; retired=1 after it.
- LW (0x23) -> ir_we, then DECODE, MEM_ADDR (alu_b_sel=2), MEM_RD (mem_addr_sel=1), then reg_we=1 with reg_wd_sel=1 on cycle 5; next cycle is FETCH.
- BNE with zero=1 -> no pc_we in BRANCH. BNE with zero=0 -> pc_we=1 with pc_src_sel=3. Both return to FETCH on cycle 4.
- JAL then JR (funct 0x08) -> JAL cycle 3 has reg_we=1, reg_dst_sel=2, reg_wd_sel=2, pc_src_sel=1. JR cycle 3 has pc_src_sel=2. retired advances by 2.
- Opcode 0x3F -> with macro: HALT, illegal=1, enables stay 0 for 10 cycles until reset. Without macro: FETCH on cycle 3.
- reset pulsed in EX_R -> no reg_we issued; FETCH follows reset release; retired=0 at that point.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS-subset control unit:
// opcode/funct constants, ALU and mux-select encodings, FSM states and
// instruction classes. MC_CTRL_ILLEGAL_TRAP_EN adds the HALT state.
package mc_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [1:0] {
      ALU_ADD = 2'd0,
      ALU_SUB = 2'd1,
      ALU_XOR = 2'd2,
      ALU_SLT = 2'd3
   } alu_op_t;

   localparam logic       ADDR_PC     = 1'b0;
   localparam logic       ADDR_ALUOUT = 1'b1;

   localparam logic [1:0] DST_RT  = 2'd0;
   localparam logic [1:0] DST_RD  = 2'd1;
   localparam logic [1:0] DST_R31 = 2'd2;

   localparam logic [1:0] WD_ALUOUT = 2'd0;
   localparam logic [1:0] WD_MDR    = 2'd1;
   localparam logic [1:0] WD_PC     = 2'd2;

   localparam logic       A_PC  = 1'b0;
   localparam logic       A_REG = 1'b1;

   localparam logic [1:0] B_REG     = 2'd0;
   localparam logic [1:0] B_FOUR    = 2'd1;
   localparam logic [1:0] B_IMM     = 2'd2;
   localparam logic [1:0] B_IMM_SH2 = 2'd3;

   localparam logic [1:0] PC_ALU    = 2'd0;
   localparam logic [1:0] PC_JUMP   = 2'd1;
   localparam logic [1:0] PC_A      = 2'd2;
   localparam logic [1:0] PC_ALUOUT = 2'd3;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEM_ADDR,
      S_MEM_RD,
      S_MEM_WB,
      S_MEM_WR,
      S_EX_R,
      S_WB_R,
      S_EX_I,
      S_WB_I,
      S_BRANCH,
      S_JUMP,
      S_JR,
      S_JAL
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      , S_HALT
`endif
   } state_t;

   typedef enum logic [3:0] {
      CL_MEM_LD,
      CL_MEM_ST,
      CL_RTYPE,
      CL_JR,
      CL_ITYPE,
      CL_BNE,
      CL_J,
      CL_JAL,
      CL_ILLEGAL
   } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: {opcode, funct} -> class, plus
// the ALU operation used by the R-type and I-type execute steps.
// Ports: opcode, funct in; iclass, alu_op out.
module mc_decode
   import mc_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output iclass_t    iclass,
   output alu_op_t    alu_op
);

   always_comb begin
      iclass = CL_ILLEGAL;
      alu_op = ALU_ADD;
      unique case (opcode)
         OP_RTYPE: begin
            unique case (funct)
               FN_ADD: begin
                  iclass = CL_RTYPE;
                  alu_op = ALU_ADD;
               end
               FN_SUB: begin
                  iclass = CL_RTYPE;
                  alu_op = ALU_SUB;
               end
               FN_SLT: begin
                  iclass = CL_RTYPE;
                  alu_op = ALU_SLT;
               end
               FN_JR:   iclass = CL_JR;
               default: iclass = CL_ILLEGAL;
            endcase
         end
         OP_LW:   iclass = CL_MEM_LD;
         OP_SW:   iclass = CL_MEM_ST;
         OP_ADDI: begin
            iclass = CL_ITYPE;
            alu_op = ALU_ADD;
         end
         OP_XORI: begin
            iclass = CL_ITYPE;
            alu_op = ALU_XOR;
         end
         OP_BNE:  iclass = CL_BNE;
         OP_J:    iclass = CL_J;
         OP_JAL:  iclass = CL_JAL;
         default: iclass = CL_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS-subset CPU plus a retired-
// instruction counter. Inputs: clk, reset (sync, active-high), opcode,
// funct, zero. Outputs: write enables, mux selects, alu_op, retired,
// illegal. Define MC_CTRL_ILLEGAL_TRAP_EN to trap unknown encodings
// into a HALT state that only reset leaves.
module multicycle_control
   import mc_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   output logic             pc_we,
   output logic             ir_we,
   output logic             mem_we,
   output logic             reg_we,
   output logic             mem_addr_sel,
   output logic [1:0]       reg_dst_sel,
   output logic [1:0]       reg_wd_sel,
   output logic             alu_a_sel,
   output logic [1:0]       alu_b_sel,
   output logic [1:0]       alu_op,
   output logic [1:0]       pc_src_sel,
   output logic [CNT_W-1:0] retired,
   output logic             illegal
);

   state_t  state;
   state_t  state_next;
   iclass_t iclass;
   alu_op_t ex_op;

   mc_decode u_decode (
      .opcode (opcode),
      .funct  (funct),
      .iclass (iclass),
      .alu_op (ex_op)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_FETCH;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         S_FETCH:  state_next = S_DECODE;
         S_DECODE: begin
            unique case (iclass)
               CL_MEM_LD, CL_MEM_ST: state_next = S_MEM_ADDR;
               CL_RTYPE: state_next = S_EX_R;
               CL_JR:    state_next = S_JR;
               CL_ITYPE: state_next = S_EX_I;
               CL_BNE:   state_next = S_BRANCH;
               CL_J:     state_next = S_JUMP;
               CL_JAL:   state_next = S_JAL;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
               default:  state_next = S_HALT;
`else
               default:  state_next = S_FETCH;
`endif
            endcase
         end
         S_MEM_ADDR: state_next = (iclass == CL_MEM_LD) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   state_next = S_MEM_WB;
         S_EX_R:     state_next = S_WB_R;
         S_EX_I:     state_next = S_WB_I;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
         S_HALT:     state_next = S_HALT;
`endif
         default:    state_next = S_FETCH;
      endcase
   end

   always_comb begin
      pc_we        = 1'b0;
      ir_we        = 1'b0;
      mem_we       = 1'b0;
      reg_we       = 1'b0;
      mem_addr_sel = ADDR_PC;
      reg_dst_sel  = DST_RT;
      reg_wd_sel   = WD_ALUOUT;
      alu_a_sel    = A_PC;
      alu_b_sel    = B_REG;
      alu_op       = ALU_ADD;
      pc_src_sel   = PC_ALU;
      unique case (state)
         S_FETCH: begin
            ir_we     = 1'b1;
            alu_b_sel = B_FOUR;
            pc_we     = 1'b1;
         end
         // Branch target precomputed into ALUOut.
         S_DECODE: alu_b_sel = B_IMM_SH2;
         S_MEM_ADDR: begin
            alu_a_sel = A_REG;
            alu_b_sel = B_IMM;
         end
         S_MEM_RD: mem_addr_sel = ADDR_ALUOUT;
         S_MEM_WB: begin
            reg_we     = 1'b1;
            reg_wd_sel = WD_MDR;
         end
         S_MEM_WR: begin
            mem_addr_sel = ADDR_ALUOUT;
            mem_we       = 1'b1;
         end
         S_EX_R: begin
            alu_a_sel = A_REG;
            alu_op    = ex_op;
         end
         S_WB_R: begin
            reg_we      = 1'b1;
            reg_dst_sel = DST_RD;
         end
         S_EX_I: begin
            alu_a_sel = A_REG;
            alu_b_sel = B_IMM;
            alu_op    = ex_op;
         end
         S_WB_I: reg_we = 1'b1;
         S_BRANCH: begin
            alu_a_sel  = A_REG;
            alu_op     = ALU_SUB;
            pc_src_sel = PC_ALUOUT;
            pc_we      = !zero;
         end
         S_JUMP: begin
            pc_src_sel = PC_JUMP;
            pc_we      = 1'b1;
         end
         S_JR: begin
            pc_src_sel = PC_A;
            pc_we      = 1'b1;
         end
         // PC already holds the return address (+4 done in FETCH).
         S_JAL: begin
            reg_we      = 1'b1;
            reg_dst_sel = DST_R31;
            reg_wd_sel  = WD_PC;
            pc_src_sel  = PC_JUMP;
            pc_we       = 1'b1;
         end
         default: ;
      endcase
      if (reset) begin
         pc_we  = 1'b0;
         ir_we  = 1'b0;
         mem_we = 1'b0;
         reg_we = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         retired <= '0;
      end else if (ir_we) begin
         retired <= retired + CNT_W'(1);
      end
   end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   assign illegal = (state == S_HALT);
`else
   assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for multicycle_control: per-instruction
// cycle counts and output patterns, plus reset and trap sequences.
module tb_multicycle_control;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        zero;
   logic        pc_we;
   logic        ir_we;
   logic        mem_we;
   logic        reg_we;
   logic        mem_addr_sel;
   logic [1:0]  reg_dst_sel;
   logic [1:0]  reg_wd_sel;
   logic        alu_a_sel;
   logic [1:0]  alu_b_sel;
   logic [1:0]  alu_op;
   logic [1:0]  pc_src_sel;
   logic [31:0] retired;
   logic        illegal;

   multicycle_control #(.CNT_W(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .opcode       (opcode),
      .funct        (funct),
      .zero         (zero),
      .pc_we        (pc_we),
      .ir_we        (ir_we),
      .mem_we       (mem_we),
      .reg_we       (reg_we),
      .mem_addr_sel (mem_addr_sel),
      .reg_dst_sel  (reg_dst_sel),
      .reg_wd_sel   (reg_wd_sel),
      .alu_a_sel    (alu_a_sel),
      .alu_b_sel    (alu_b_sel),
      .alu_op       (alu_op),
      .pc_src_sel   (pc_src_sel),
      .retired      (retired),
      .illegal      (illegal)
   );

   always #5 clk = ~clk;

   wire [15:0] outs = {pc_we, ir_we, mem_we, reg_we, mem_addr_sel,
                       reg_dst_sel, reg_wd_sel, alu_a_sel, alu_b_sel,
                       alu_op, pc_src_sel};
   wire [3:0] wes = {pc_we, ir_we, mem_we, reg_we};

   typedef struct {
      string      name;
      logic [5:0] op;
      logic [5:0] fn;
      logic       z;
      int         cyc;
      logic [15:0] e3;
      logic [15:0] el;
   } vec_t;

   vec_t vecs[$];
   int   passed = 0;
   int   total  = 0;
   int   exp_ret = 0;

   function automatic logic [15:0] mk(
      input bit pw, input bit iw, input bit mw, input bit rw,
      input bit mas, input bit [1:0] rds, input bit [1:0] rws,
      input bit aas, input bit [1:0] abs, input bit [1:0] aop,
      input bit [1:0] pcs);
      return {pw, iw, mw, rw, mas, rds, rws, aas, abs, aop, pcs};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Starts in a FETCH cycle, leaves the bench in the next FETCH cycle.
   task automatic run(input vec_t x);
      logic [15:0] f_pat;
      logic [15:0] d_pat;
      f_pat = mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      d_pat = mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
      opcode = x.op;
      funct  = x.fn;
      zero   = x.z;
      #1;
      chk({x.name, "/fetch"}, 32'(outs), 32'(f_pat));
      chk({x.name, "/ret0"}, retired, exp_ret);
      exp_ret++;
      for (int c = 2; c <= x.cyc; c++) begin
         step();
         if (c == 2) begin
            chk({x.name, "/decode"}, 32'(outs), 32'(d_pat));
            chk({x.name, "/ret1"}, retired, exp_ret);
         end
         if (c == 3) chk({x.name, "/c3"}, 32'(outs), 32'(x.e3));
         if (c == x.cyc && c > 3) chk({x.name, "/last"}, 32'(outs), 32'(x.el));
      end
      step();
   endtask

   function automatic vec_t mv(input string n, input logic [5:0] op,
                               input logic [5:0] fn, input logic z,
                               input int cyc, input logic [15:0] e3,
                               input logic [15:0] el);
      vec_t r;
      r.name = n; r.op = op; r.fn = fn; r.z = z;
      r.cyc = cyc; r.e3 = e3; r.el = el;
      return r;
   endfunction

   initial begin
      vecs.push_back(mv("lw", 6'h23, 6'h00, 0, 5,
         mk(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0),
         mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0)));
      vecs.push_back(mv("sw", 6'h2B, 6'h00, 0, 4,
         mk(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0),
         mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0)));
      vecs.push_back(mv("add", 6'h00, 6'h20, 0, 4,
         mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0),
         mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0)));
      vecs.push_back(mv("sub", 6'h00, 6'h22, 0, 4,
         mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0),
         mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0)));
      vecs.push_back(mv("slt", 6'h00, 6'h2A, 0, 4,
         mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0),
         mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0)));
      vecs.push_back(mv("addi", 6'h08, 6'h00, 0, 4,
         mk(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0),
         mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0)));
      vecs.push_back(mv("xori", 6'h0E, 6'h00, 0, 4,
         mk(0, 0, 0, 0, 0, 0, 0, 1, 2, 2, 0),
         mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0)));
      vecs.push_back(mv("bne_z1", 6'h05, 6'h00, 1, 3,
         mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 3), 16'h0));
      vecs.push_back(mv("bne_z0", 6'h05, 6'h00, 0, 3,
         mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 3), 16'h0));
      vecs.push_back(mv("j", 6'h02, 6'h00, 0, 3,
         mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 16'h0));
      vecs.push_back(mv("jal", 6'h03, 6'h00, 0, 3,
         mk(1, 0, 0, 1, 0, 2, 2, 0, 0, 0, 1), 16'h0));
      vecs.push_back(mv("jr", 6'h00, 6'h08, 0, 3,
         mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2), 16'h0));
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
      vecs.push_back(mv("ill_op", 6'h3F, 6'h00, 0, 2, 16'h0, 16'h0));
      vecs.push_back(mv("ill_fn", 6'h00, 6'h3F, 0, 2, 16'h0, 16'h0));
`endif

      reset = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_we", 32'(wes), 32'h0);
      end
      chk("rst_ret", retired, 32'd0);
      chk("rst_ill", 32'(illegal), 32'd0);
      reset = 1'b0;
      #1;
      chk("first_fetch", 32'({ir_we, pc_we}), 32'h3);

      foreach (vecs[i]) run(vecs[i]);

      // JAL then JR: retired advances by two.
      begin
         int base;
         base = exp_ret;
         run(vecs[10]);
         run(vecs[11]);
         #1;
         chk("jal_jr_ret", retired, 32'(base + 2));
      end

      // Reset pulsed during EX_R abandons the add without a write.
      opcode = 6'h00; funct = 6'h20; zero = 1'b0;
      #1;
      step();
      step();
      chk("exr_state", 32'(outs),
          32'(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0)));
      reset = 1'b1;
      #1;
      chk("exr_rst_we", 32'(wes), 32'h0);
      step();
      chk("exr_no_wb", 32'(wes), 32'h0);
      reset = 1'b0;
      #1;
      chk("exr_refetch", 32'({ir_we, pc_we}), 32'h3);
      chk("exr_ret0", retired, 32'd0);
      exp_ret = 0;
      run(vecs[0]);

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      opcode = 6'h3F; funct = 6'h00;
      #1;
      step();
      for (int i = 0; i < 10; i++) begin
         step();
         chk("halt_ill", 32'(illegal), 32'd1);
         chk("halt_we", 32'(wes), 32'h0);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      chk("halt_exit_ill", 32'(illegal), 32'd0);
      chk("halt_exit_fetch", 32'(ir_we), 32'd1);
`else
      chk("no_trap_ill", 32'(illegal), 32'd0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
